// File: rtl/pwm_int_event_gen.sv
// Per-channel interrupt event generator: selects carrier zero/peak strobes, decimates them,
// and emits registered single-cycle event pulses plus sticky status flags.
module pwm_int_event_gen #(
   parameter int N_CH  = 8,
   parameter int DEC_W = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic [N_CH-1:0]         evt_zero,
   input  logic [N_CH-1:0]         evt_peak,
   input  logic [2*N_CH-1:0]       cfg_src,
   input  logic [DEC_W*N_CH-1:0]   cfg_dec,
   input  logic                    cfg_load,
   input  logic [N_CH-1:0]         sticky_clr,
   output logic [N_CH-1:0]         event_out,
   output logic [N_CH-1:0]         evt_sticky,
   output logic [DEC_W*N_CH-1:0]   dec_cnt_dbg
);

   logic [N_CH-1:0][DEC_W-1:0] cnt;
   logic [N_CH-1:0][DEC_W-1:0] cnt_nxt;
   logic [N_CH-1:0]            sel;
   logic [N_CH-1:0]            fire;

   always_comb begin
      sel     = '0;
      fire    = '0;
      cnt_nxt = cnt;
      for (int unsigned i = 0; i < N_CH; i++) begin
         // zero and peak in the same cycle collapse into a single event
         sel[i] = (cfg_src[2*i] & evt_zero[i]) | (cfg_src[2*i+1] & evt_peak[i]);
         if (cfg_load) begin
            cnt_nxt[i] = '0;
         end else if (en) begin
            if (cfg_src[2*i +: 2] == 2'b00) begin
               cnt_nxt[i] = '0;
            end else if (sel[i]) begin
               // >= rather than == so a lowered D fires on the next event instead of wrapping
               if (cnt[i] >= cfg_dec[DEC_W*i +: DEC_W]) begin
                  fire[i]    = 1'b1;
                  cnt_nxt[i] = '0;
               end else begin
                  cnt_nxt[i] = cnt[i] + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt        <= '0;
         event_out  <= '0;
         evt_sticky <= '0;
      end else begin
         cnt        <= cnt_nxt;
         event_out  <= fire;
         // set beats clear so an event coinciding with a software clear is not lost
         evt_sticky <= (evt_sticky & ~sticky_clr) | fire;
      end
   end

   assign dec_cnt_dbg = cnt;

endmodule

// File: tb/tb_pwm_int_event_gen.sv
// Self-checking bench for pwm_int_event_gen: expected pulse vectors are queued as stimulus is
// driven and compared against captured event_out when each task drains its scoreboard.
module tb_pwm_int_event_gen;

   localparam int N_CH  = 8;
   localparam int DEC_W = 4;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  en;
   logic [N_CH-1:0]       evt_zero;
   logic [N_CH-1:0]       evt_peak;
   logic [2*N_CH-1:0]     cfg_src;
   logic [DEC_W*N_CH-1:0] cfg_dec;
   logic                  cfg_load;
   logic [N_CH-1:0]       sticky_clr;
   logic [N_CH-1:0]       event_out;
   logic [N_CH-1:0]       evt_sticky;
   logic [DEC_W*N_CH-1:0] dec_cnt_dbg;

   int errors = 0;
   int checks = 0;
   logic [N_CH-1:0] exp_q[$];
   logic [N_CH-1:0] obs_q[$];
   logic [N_CH-1:0] e, o;

   pwm_int_event_gen #(.N_CH(N_CH), .DEC_W(DEC_W)) dut (
      .clk(clk), .reset(reset), .en(en), .evt_zero(evt_zero), .evt_peak(evt_peak),
      .cfg_src(cfg_src), .cfg_dec(cfg_dec), .cfg_load(cfg_load), .sticky_clr(sticky_clr),
      .event_out(event_out), .evt_sticky(evt_sticky), .dec_cnt_dbg(dec_cnt_dbg)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one clock with the given strobes; queues the pulse vector expected right after the edge
   task automatic cyc(input logic [N_CH-1:0] z, input logic [N_CH-1:0] p, input logic [N_CH-1:0] x);
      evt_zero = z;
      evt_peak = p;
      exp_q.push_back(x);
      tick();
      obs_q.push_back(event_out);
      evt_zero = '0;
      evt_peak = '0;
   endtask

   task automatic setup(input int ch, input logic [1:0] src, input logic [DEC_W-1:0] d);
      cfg_src    = '0;
      sticky_clr = '1;
      tick();
      sticky_clr = '0;
      cfg_src[2*ch +: 2]       = src;
      cfg_dec[DEC_W*ch +: DEC_W] = d;
   endtask

   function automatic logic [DEC_W-1:0] cnt_of(input int ch);
      return dec_cnt_dbg[DEC_W*ch +: DEC_W];
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      #3;
      checks++; if (event_out !== '0) begin errors++; $display("FAIL reset_event got %h expected 00", event_out); end
      checks++; if (evt_sticky !== '0) begin errors++; $display("FAIL reset_sticky got %h expected 00", evt_sticky); end
      checks++; if (dec_cnt_dbg !== '0) begin errors++; $display("FAIL reset_cnt got %h expected 0", dec_cnt_dbg); end
      tick();
      reset = 1'b0;
      tick();
      setup(0, 2'b01, 4'd3);
      cyc(8'h01, 8'h00, 8'h00);
      cyc(8'h01, 8'h00, 8'h00);
      checks++; if (cnt_of(0) !== 4'd2) begin errors++; $display("FAIL midcount_cnt got %0d expected 2", cnt_of(0)); end
      reset = 1'b1;
      #1;
      checks++; if (event_out !== '0) begin errors++; $display("FAIL async_event got %h expected 00", event_out); end
      checks++; if (evt_sticky !== '0) begin errors++; $display("FAIL async_sticky got %h expected 00", evt_sticky); end
      checks++; if (dec_cnt_dbg !== '0) begin errors++; $display("FAIL async_cnt got %h expected 0", dec_cnt_dbg); end
      #1;
      reset = 1'b0;
      for (int k = 1; k <= 4; k++) cyc(8'h01, 8'h00, (k == 4) ? 8'h01 : 8'h00);
      cyc(8'h00, 8'h00, 8'h00);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL reset_pulse got %h expected %h", o, e); end
      end
   endtask

   task automatic test_decimation();
      setup(2, 2'b10, 4'd2);
      for (int k = 1; k <= 9; k++) begin
         cyc(8'h00, 8'h04, (k % 3 == 0) ? 8'h04 : 8'h00);
         if (k == 2) begin
            checks++; if (evt_sticky[2] !== 1'b0) begin errors++; $display("FAIL dec_sticky_pre got %b expected 0", evt_sticky[2]); end
         end
         if (k == 3) begin
            checks++; if (evt_sticky[2] !== 1'b1) begin errors++; $display("FAIL dec_sticky got %b expected 1", evt_sticky[2]); end
         end
         for (int g = 0; g < 4; g++) cyc(8'h00, 8'h00, 8'h00);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL dec_pulse got %h expected %h", o, e); end
      end
   endtask

   task automatic test_both_sources();
      setup(5, 2'b11, 4'd0);
      cyc(8'h20, 8'h20, 8'h20);
      cyc(8'h00, 8'h00, 8'h00);
      cyc(8'h00, 8'h00, 8'h00);
      cyc(8'h00, 8'h20, 8'h20);
      cyc(8'h00, 8'h00, 8'h00);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL both_pulse got %h expected %h", o, e); end
      end
   endtask

   task automatic test_lower_dec();
      setup(1, 2'b01, 4'd7);
      for (int k = 0; k < 5; k++) cyc(8'h02, 8'h00, 8'h00);
      checks++; if (cnt_of(1) !== 4'd5) begin errors++; $display("FAIL lower_cnt_pre got %0d expected 5", cnt_of(1)); end
      cfg_dec[DEC_W*1 +: DEC_W] = 4'd2;
      cyc(8'h02, 8'h00, 8'h02);
      checks++; if (cnt_of(1) !== 4'd0) begin errors++; $display("FAIL lower_cnt_post got %0d expected 0", cnt_of(1)); end
      cyc(8'h00, 8'h00, 8'h00);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL lower_pulse got %h expected %h", o, e); end
      end
   endtask

   task automatic test_cfg_load();
      setup(3, 2'b01, 4'd1);
      cyc(8'h08, 8'h00, 8'h00);
      checks++; if (cnt_of(3) !== 4'd1) begin errors++; $display("FAIL load_cnt_pre got %0d expected 1", cnt_of(3)); end
      cfg_load = 1'b1;
      cyc(8'h08, 8'h00, 8'h00);
      cfg_load = 1'b0;
      checks++; if (cnt_of(3) !== 4'd0) begin errors++; $display("FAIL load_cnt got %0d expected 0", cnt_of(3)); end
      cyc(8'h08, 8'h00, 8'h00);
      cyc(8'h08, 8'h00, 8'h08);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL load_pulse got %h expected %h", o, e); end
      end
   endtask

   task automatic test_sticky_en();
      setup(4, 2'b01, 4'd0);
      sticky_clr = 8'h10;
      cyc(8'h10, 8'h00, 8'h10);
      sticky_clr = '0;
      checks++; if (evt_sticky[4] !== 1'b1) begin errors++; $display("FAIL race_sticky got %b expected 1", evt_sticky[4]); end
      sticky_clr = 8'h10;
      tick();
      sticky_clr = '0;
      checks++; if (evt_sticky[4] !== 1'b0) begin errors++; $display("FAIL clr_sticky got %b expected 0", evt_sticky[4]); end
      cfg_dec[DEC_W*4 +: DEC_W] = 4'd3;
      cyc(8'h10, 8'h00, 8'h00);
      en = 1'b0;
      for (int k = 0; k < 3; k++) cyc(8'h10, 8'h00, 8'h00);
      checks++; if (cnt_of(4) !== 4'd1) begin errors++; $display("FAIL en_cnt got %0d expected 1", cnt_of(4)); end
      en = 1'b1;
      cyc(8'h10, 8'h00, 8'h00);
      cyc(8'h10, 8'h00, 8'h00);
      cyc(8'h10, 8'h00, 8'h10);
      en = 1'b0;
      tick();
      checks++; if (evt_sticky[4] !== 1'b1) begin errors++; $display("FAIL en_sticky_hold got %b expected 1", evt_sticky[4]); end
      en = 1'b1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL en_pulse got %h expected %h", o, e); end
      end
   endtask

   task automatic test_back_to_back();
      setup(6, 2'b10, 4'd0);
      cfg_src[2*7 +: 2]       = 2'b11;
      cfg_dec[DEC_W*7 +: DEC_W] = 4'd1;
      cyc(8'h80, 8'h40, 8'h40);
      cyc(8'h00, 8'hC0, 8'hC0);
      cyc(8'h00, 8'h40, 8'h40);
      cfg_src[2*6 +: 2] = 2'b00;
      cyc(8'h00, 8'h40, 8'h00);
      checks++; if (cnt_of(6) !== 4'd0) begin errors++; $display("FAIL off_cnt got %0d expected 0", cnt_of(6)); end
      setup(0, 2'b01, 4'd15);
      for (int k = 1; k <= 16; k++) begin
         cyc(8'h01, 8'h00, (k == 16) ? 8'h01 : 8'h00);
         if (k == 15) begin
            checks++; if (cnt_of(0) !== 4'd15) begin errors++; $display("FAIL max_cnt got %0d expected 15", cnt_of(0)); end
         end
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL b2b_pulse got %h expected %h", o, e); end
      end
   endtask

   initial begin
      en = 1'b1; evt_zero = '0; evt_peak = '0; cfg_src = '0; cfg_dec = '0;
      cfg_load = 1'b0; sticky_clr = '0;
      test_reset();
      test_decimation();
      test_both_sources();
      test_lower_dec();
      test_cfg_load();
      test_sticky_en();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pwm_int_event_gen.md
Name: pwm_int_event_gen

Overview:
- Per-channel interrupt event generator for the cPWM core.
- Sits directly upstream of the interrupt routing matrix and drives its per-channel interrupt_in vector.
- Converts raw carrier strobes from each PWM channel (counter-zero and counter-peak) into decimated, single-cycle interrupt event pulses.
- Keeps a sticky per-channel event flag that software reads and clears.

Parameters:
- N_CH, 8, number of PWM channels; equals the PWM_WIDTH package constant.
- DEC_W, 4, width of the per-channel decimation field; allows 1 to 2^DEC_W events per pulse.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  global enable; 0 freezes all counters and suppresses pulses
- evt_zero  in  N_CH  one-cycle strobe when channel carrier reaches zero
- evt_peak  in  N_CH  one-cycle strobe when channel carrier reaches peak
- cfg_src  in  2*N_CH  per-channel source select, bits [2i+1:2i]: 00 off, 01 zero, 10 peak, 11 zero or peak
- cfg_dec  in  DEC_W*N_CH  per-channel decimation D, bits [DEC_W*i +: DEC_W]; pulse on every (D+1)-th selected event
- cfg_load  in  1  one-cycle strobe; restarts all decimation counters
- sticky_clr  in  N_CH  per-channel clear of sticky flag (write-one-to-clear pulse)
- event_out  out  N_CH  registered one-cycle event pulses; feed the interrupt_in of the matrix
- evt_sticky  out  N_CH  sticky per-channel event flags for the status register
- dec_cnt_dbg  out  DEC_W*N_CH  current decimation counter values (debug/readback)

Behaviour:
- Reset (asynchronous, active-high) forces event_out=0, evt_sticky=0 and every decimation counter to 0.
- Selected event for channel i: sel_i = (cfg_src[2i] & evt_zero[i]) | (cfg_src[2i+1] & evt_peak[i]).
  - With src=11, zero and peak asserted in the same cycle count as ONE event.
- Per channel, on a clk edge with en=1, cfg_load=0 and sel_i=1:
  - if cnt_i >= D_i: event_out[i]<=1 next cycle, cnt_i<=0;
  - otherwise cnt_i<=cnt_i+1 and event_out[i]<=0.
- Counter arithmetic is unsigned, DEC_W bits. The >= compare handles D being lowered below the current count: the next selected event fires and wraps. The counter never overflows.
- Latency: strobe in cycle N produces the event_out pulse in cycle N+1, exactly one clk wide.
- event_out is 0 in any cycle with no qualifying firing event.
- D=0: every selected event produces a pulse; back-to-back strobes give back-to-back pulses.
- src=00: cnt_i is held at 0 and no pulses are generated. Re-enabling a source starts counting from 0.
- en=0: counters hold their value, event_out=0, evt_sticky holds (sticky_clr still honoured).
- cfg_load=1: all counters <=0 in that cycle, any sel in that cycle is ignored, no pulse results. cfg_load takes priority over en and sel.
- Sticky flag:
  - evt_sticky[i] sets in the same cycle event_out[i] asserts.
  - It clears on sticky_clr[i]=1.
  - Set and clear in the same cycle: set wins (no event lost).
- Channels are fully independent; no cross-channel priority.
- Configuration inputs are sampled every cycle and are not registered internally.

Test Plan:
- Reset mid-count: ch0 src=01, D=3, 2 zero strobes, then assert reset -> event_out=0, evt_sticky=0, dec_cnt_dbg=0 immediately (asynchronous). After release, 4 more strobes give exactly one pulse, on the cycle after the 4th.
- Decimation: ch2 src=10, D=2, 9 peak strobes spaced 5 cycles -> 3 pulses, each 1 cycle wide, one cycle after strobes 3, 6 and 9. evt_sticky[2]=1 after the first pulse.
- Both sources: ch5 src=11, D=0, evt_zero and evt_peak together in one cycle, then peak alone 3 cycles later -> exactly 2 pulses.
- D lowered below count: ch1 src=01, D=7, 5 strobes (cnt=5), then set D=2 and send 1 strobe -> pulse next cycle, cnt=0.
- cfg_load collision: ch3 D=1, cnt=1; cfg_load and a zero strobe in the same cycle -> no pulse, cnt=0. The next two strobes give one pulse.
- Sticky set/clear race and en gating:
  - sticky_clr[4] asserted in the same cycle as a firing event -> evt_sticky[4] stays 1.
  - en=0 with strobes -> no pulses, cnt unchanged.
